sw_alloc_rr: RTL and testbench
==============================

Name: sw_alloc_rr

Overview:
- Switch allocator for the 5-port mesh router (R, L, U, D, EJ).
- Each input buffer presents a head flit with a 3-bit destination port code. The block arbitrates per output port with round-robin fairness and locks the output to the winner until its tail flit passes (wormhole).
- Drives the crossbar select codes and the per-input grant / per-output valid handshakes.
- Sits between the input buffers, the crossbar and the output buffers.

Parameters:
- NP, 5, number of router ports. Index 0=R, 1=L, 2=U, 3=D, 4=EJ.
- PW, 3, width of a port code. Code 3'b111 means "no source".

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- req_valid  input  NP  input i holds a flit ready to move.
- req_dst  input  NP*PW  destination port code of input i; slice [i*PW +: PW].
- req_tail  input  NP  flit at input i is a packet tail. A single-flit packet sets it on the head.
- out_ready  input  NP  output buffer o can accept a flit this cycle.
- grant  output  NP  flit at input i is transferred this cycle; the input pops.
- out_valid  output  NP  output buffer o writes the crossbar output this cycle.
- xbar_sel  output  NP*PW  source input for output o; 3'b111 when idle.
- busy  output  NP  output o is locked to an owner.
- err_bad_dst  output  1  sticky; set when a valid request carries dst >= NP.

Behaviour:
- Reset: all output FSMs go to IDLE and every rr_ptr to 0. All outputs are 0 except xbar_sel, which is all 3'b111. err_bad_dst clears.
- Reset mid-packet drops every lock immediately. grant and out_valid are 0 in the reset cycle.
- Per-output FSM (o = 0..NP-1) has two states, IDLE and LOCKED, plus registers owner[o] and rr_ptr[o].
- IDLE:
  - Candidate set = {i : req_valid[i] && req_dst[i]==o && input i not owner of any LOCKED output}.
  - The winner is the first candidate at or after rr_ptr[o], searching upward modulo NP.
  - If the set is non-empty: owner <= winner, next state LOCKED. Otherwise stay IDLE.
  - No grant is issued in the IDLE cycle. Allocation latency is 1 cycle.
- LOCKED:
  - busy[o]=1 and xbar_sel[o]=owner.
  - fire = req_valid[owner] && req_dst[owner]==o && out_ready[o].
  - grant[owner]=fire and out_valid[o]=fire, both combinational from the current state and inputs.
  - If fire && req_tail[owner]: next state IDLE and rr_ptr[o] <= (owner+1) mod NP.
  - A bubble (req_valid low) or backpressure (out_ready low) holds the lock with no transfer.
- Throughput: a packet of F flits with no stalls occupies the output for F+1 cycles (1 allocation + F transfers). The released output re-arbitrates in the cycle after the tail.
- Simultaneous events:
  - Several inputs targeting one output are resolved by rr_ptr.
  - Different outputs allocate independently in the same cycle.
  - An input owns at most one output. It requests a single dst, and the candidate exclusion covers the case where its dst changes.
- Bad dst: a valid request with dst >= NP is never a candidate and sets err_bad_dst, which stays set until reset.
- grant is one-hot per input at most: each input has one owner slot.

Decomposition:
- Shared package router_pkg holds:
  - NP and PW;
  - port codes P_R=0, P_L=1, P_U=2, P_D=3, P_EJ=4;
  - SEL_NONE=3'b111;
  - the FSM state encoding (IDLE=0, LOCKED=1).
- One natural sub-module: rr_arbiter, an NP-wide round-robin pick given a request vector and a pointer, returning a one-hot winner plus its index. Instantiate it NP times, one per output.

Test Plan:
1. Single-flit packet:
   - Stimulus: reset, then input 4 (EJ) with req_dst=0, req_tail=1, out_ready=all 1.
   - Required: cycle 1 busy[0]=1, xbar_sel[0]=4; cycle 2 grant[4]=1, out_valid[0]=1; cycle 3 busy[0]=0, xbar_sel[0]=7, rr_ptr[0]=0.
2. Contention with round-robin:
   - Stimulus: inputs 1 and 3 both send 2-flit packets to output 2.
   - Required: input 1 wins first, with grants on 2 consecutive cycles. Input 3 is then granted after a 1-cycle re-allocation. The next contention between 1 and 3 goes to 1, since rr_ptr=4 wraps to 0, then 1.
3. Backpressure:
   - Stimulus: locked 3-flit packet; drop out_ready[o] for 2 cycles after flit 1.
   - Required: grant and out_valid are 0 during the stall, the lock is held, and the total is 6 cycles from allocation to release.
4. Parallel outputs:
   - Stimulus: input 0 to output 1 and input 2 to output 3 in the same cycle.
   - Required: both lock in the same cycle and both grant the next cycle.
5. Reset mid-packet:
   - Stimulus: assert reset during flit 2 of a 4-flit packet.
   - Required: in the same cycle grant=0, out_valid=0; busy=0 and xbar_sel all 3'b111 next cycle. A new request is allocated normally after reset deasserts.
6. Bad destination:
   - Stimulus: req_valid[2]=1 with req_dst=6.
   - Required: no grant, err_bad_dst=1, and it stays 1 until reset.

Source files
------------

// File: rtl/router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : router_pkg
// Brief  : Shared constants and FSM encoding for the 5-port mesh router.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int NP = 5;
  localparam int PW = 3;

  localparam logic [PW-1:0] P_R      = 3'd0;
  localparam logic [PW-1:0] P_L      = 3'd1;
  localparam logic [PW-1:0] P_U      = 3'd2;
  localparam logic [PW-1:0] P_D      = 3'd3;
  localparam logic [PW-1:0] P_EJ     = 3'd4;
  localparam logic [PW-1:0] SEL_NONE = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : NP-wide round-robin pick: first request at or after ptr, wrapping.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module rr_arbiter
  import router_pkg::*;
(
  input  logic [NP-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NP-1:0] gnt,
  output logic [PW-1:0] idx
);

  logic          w_hi_found;
  logic          w_lo_found;
  logic [PW-1:0] w_hi_idx;
  logic [PW-1:0] w_lo_idx;

  // Descending scans leave the lowest matching index in each candidate.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = PW'(i);
        if (PW'(i) >= ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = PW'(i);
        end
      end
    end
  end

  always_comb begin
    idx = SEL_NONE;
    if (w_hi_found) begin
      idx = w_hi_idx;
    end else if (w_lo_found) begin
      idx = w_lo_idx;
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NP; i++) begin
      gnt[i] = (idx == PW'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/sw_alloc_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sw_alloc_rr
// Brief  : Wormhole switch allocator, one round-robin locked FSM per output.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sw_alloc_rr
  import router_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NP-1:0]    req_valid,
  input  logic [NP*PW-1:0] req_dst,
  input  logic [NP-1:0]    req_tail,
  input  logic [NP-1:0]    out_ready,
  output logic [NP-1:0]    grant,
  output logic [NP-1:0]    out_valid,
  output logic [NP*PW-1:0] xbar_sel,
  output logic [NP-1:0]    busy,
  output logic             err_bad_dst
);

  logic [NP-1:0]         w_locked;
  logic [NP-1:0]         w_fire;
  logic [NP-1:0][PW-1:0] w_owner;
  logic [NP-1:0]         w_owned;
  logic                  w_bad;
  logic                  r_err;

  always_comb begin
    w_owned = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (w_locked[o] && (w_owner[o] == PW'(i))) w_owned[i] = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (w_fire[o] && (w_owner[o] == PW'(i))) grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (req_valid[i] && (req_dst[i*PW +: PW] >= PW'(NP))) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= r_err | w_bad;
  end

  assign err_bad_dst = r_err;

  for (genvar o = 0; o < NP; o++) begin : g_out
    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win_idx;
    logic [NP-1:0] w_cand;
    logic [NP-1:0] w_win_oh;
    logic          w_own_valid;
    logic          w_own_tail;

    // Inputs already holding another output are excluded even if dst moved.
    always_comb begin
      w_cand = '0;
      for (int i = 0; i < NP; i++) begin
        w_cand[i] = req_valid[i] && (req_dst[i*PW +: PW] == PW'(o)) && !w_owned[i];
      end
    end

    always_comb begin
      w_own_valid = 1'b0;
      w_own_tail  = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (r_owner == PW'(i)) begin
          w_own_valid = req_valid[i] && (req_dst[i*PW +: PW] == PW'(o));
          w_own_tail  = req_tail[i];
        end
      end
    end

    rr_arbiter u_arb (
      .req (w_cand),
      .ptr (r_ptr),
      .gnt (w_win_oh),
      .idx (w_win_idx)
    );

    assign w_fire[o] = (r_state == ST_LOCKED) && w_own_valid && out_ready[o] && !reset;

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_IDLE:   if (|w_win_oh) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (w_fire[o] && w_own_tail) w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_owner <= '0;
        r_ptr   <= '0;
      end else begin
        r_state <= w_state_nxt;
        if ((r_state == ST_IDLE) && (|w_win_oh)) r_owner <= w_win_idx;
        if ((r_state == ST_LOCKED) && (w_state_nxt == ST_IDLE))
          r_ptr <= (r_owner == PW'(NP - 1)) ? '0 : r_owner + PW'(1);
      end
    end

    assign w_locked[o]           = (r_state == ST_LOCKED);
    assign w_owner[o]            = r_owner;
    assign busy[o]               = w_locked[o];
    assign out_valid[o]          = w_fire[o];
    assign xbar_sel[o*PW +: PW]  = w_locked[o] ? r_owner : SEL_NONE;
  end

endmodule
`default_nettype wire

// File: tb/tb_sw_alloc_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_sw_alloc_rr
// Brief  : Vector table, directed corner sequences and random model check.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_sw_alloc_rr;

  localparam int NP = 5;
  localparam int PW = 3;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    req_valid;
  logic [NP*PW-1:0] req_dst;
  logic [NP-1:0]    req_tail;
  logic [NP-1:0]    out_ready;
  logic [NP-1:0]    grant;
  logic [NP-1:0]    out_valid;
  logic [NP*PW-1:0] xbar_sel;
  logic [NP-1:0]    busy;
  logic             err_bad_dst;

  int n_tests = 0;
  int n_fail  = 0;

  sw_alloc_rr dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_dst     (req_dst),
    .req_tail    (req_tail),
    .out_ready   (out_ready),
    .grant       (grant),
    .out_valid   (out_valid),
    .xbar_sel    (xbar_sel),
    .busy        (busy),
    .err_bad_dst (err_bad_dst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [4:0]  rv;
    logic [14:0] rd;
    logic [4:0]  rt;
    logic [4:0]  rdy;
    logic [4:0]  g;
    logic [4:0]  ov;
    logic [4:0]  bz;
    logic [14:0] xs;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [14:0] pk(input int a0, input int a1, input int a2, input int a3, input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic vec_t mk(input logic [4:0] rv, input logic [14:0] rd, input logic [4:0] rt,
                              input logic [4:0] g, input logic [4:0] ov, input logic [4:0] bz,
                              input logic [14:0] xs, input logic err);
    vec_t v;
    v.rst = 1'b0; v.rv = rv; v.rd = rd; v.rt = rt; v.rdy = 5'b11111;
    v.g = g; v.ov = ov; v.bz = bz; v.xs = xs; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rst, input logic [4:0] rv, input logic [14:0] rd,
                     input logic [4:0] rt, input logic [4:0] rdy);
    @(negedge clk);
    reset = rst; req_valid = rv; req_dst = rd; req_tail = rt; out_ready = rdy;
    #1;
  endtask

  // Reference model: per-output lock state kept as plain integers.
  int m_locked[NP];
  int m_owner[NP];
  int m_ptr[NP];
  int m_err;
  int n_locked[NP];
  int n_owner[NP];
  int n_ptr[NP];
  int n_err;

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_locked[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_eval(input logic rst, input logic [4:0] rv, input logic [14:0] rd,
                            input logic [4:0] rt, input logic [4:0] rdy,
                            output logic [4:0] g, output logic [4:0] ov, output logic [4:0] bz,
                            output logic [14:0] xs, output logic err);
    int dst[NP];
    bit owned[NP];
    bit bad;
    g = '0; ov = '0; bz = '0; xs = '1; err = m_err[0];
    bad = 0;
    for (int i = 0; i < NP; i++) begin
      dst[i] = int'(rd[i*3 +: 3]);
      owned[i] = 0;
      if (rv[i] && dst[i] >= NP) bad = 1;
    end
    for (int o = 0; o < NP; o++)
      if (m_locked[o] != 0) owned[m_owner[o]] = 1;
    for (int o = 0; o < NP; o++) begin
      n_locked[o] = m_locked[o]; n_owner[o] = m_owner[o]; n_ptr[o] = m_ptr[o];
      if (m_locked[o] != 0) begin
        int w;
        bit fire;
        w = m_owner[o];
        bz[o] = 1'b1;
        xs[o*3 +: 3] = 3'(w);
        fire = rv[w] && dst[w] == o && rdy[o] && !rst;
        if (fire) begin
          g[w] = 1'b1;
          ov[o] = 1'b1;
          if (rt[w]) begin
            n_locked[o] = 0;
            n_ptr[o] = (w + 1) % NP;
          end
        end
      end else begin
        for (int k = 0; k < NP; k++) begin
          int i;
          i = (m_ptr[o] + k) % NP;
          if (rv[i] && dst[i] == o && !owned[i]) begin
            n_locked[o] = 1;
            n_owner[o] = i;
            break;
          end
        end
      end
    end
    n_err = (m_err != 0 || bad) ? 1 : 0;
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        n_locked[o] = 0; n_owner[o] = 0; n_ptr[o] = 0;
      end
      n_err = 0;
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < NP; o++) begin
      m_locked[o] = n_locked[o]; m_owner[o] = n_owner[o]; m_ptr[o] = n_ptr[o];
    end
    m_err = n_err;
  endtask

  initial begin
    logic [14:0] d2, d4, dbad, d3, d1;
    logic [4:0]  e_g, e_ov, e_bz;
    logic [14:0] e_xs;
    logic        e_err;

    reset = 1'b1; req_valid = '0; req_dst = '0; req_tail = '0; out_ready = '1;
    repeat (2) @(posedge clk);

    d2   = pk(0, 2, 0, 2, 0);
    d4   = pk(1, 0, 3, 0, 0);
    dbad = pk(0, 0, 6, 0, 0);
    // single-flit packet from EJ to R
    tbl.push_back(mk(5'b10000, 15'h0, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    tbl.push_back(mk(5'b10000, 15'h0, 5'b10000, 5'b10000, 5'b00001, 5'b00001, pk(4,7,7,7,7), 1'b0));
    tbl.push_back(mk(5'b00000, 15'h0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    // inputs 1 and 3 contend for output 2 with 2-flit packets
    tbl.push_back(mk(5'b01010, d2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    tbl.push_back(mk(5'b01010, d2, 5'b00000, 5'b00010, 5'b00100, 5'b00100, pk(7,7,1,7,7), 1'b0));
    tbl.push_back(mk(5'b01010, d2, 5'b00010, 5'b00010, 5'b00100, 5'b00100, pk(7,7,1,7,7), 1'b0));
    tbl.push_back(mk(5'b01000, d2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    tbl.push_back(mk(5'b01000, d2, 5'b00000, 5'b01000, 5'b00100, 5'b00100, pk(7,7,3,7,7), 1'b0));
    tbl.push_back(mk(5'b01000, d2, 5'b01000, 5'b01000, 5'b00100, 5'b00100, pk(7,7,3,7,7), 1'b0));
    tbl.push_back(mk(5'b01010, d2, 5'b01010, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    tbl.push_back(mk(5'b01010, d2, 5'b01010, 5'b00010, 5'b00100, 5'b00100, pk(7,7,1,7,7), 1'b0));
    tbl.push_back(mk(5'b01000, d2, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    tbl.push_back(mk(5'b01000, d2, 5'b01000, 5'b01000, 5'b00100, 5'b00100, pk(7,7,3,7,7), 1'b0));
    tbl.push_back(mk(5'b00000, d2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    // parallel allocation: 0 -> 1 and 2 -> 3
    tbl.push_back(mk(5'b00101, d4, 5'b00101, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    tbl.push_back(mk(5'b00101, d4, 5'b00101, 5'b00101, 5'b01010, 5'b01010, pk(7,0,7,2,7), 1'b0));
    tbl.push_back(mk(5'b00000, d4, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    // bad destination is sticky
    tbl.push_back(mk(5'b00100, dbad, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b0));
    tbl.push_back(mk(5'b00000, dbad, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b1));
    tbl.push_back(mk(5'b00100, dbad, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 15'h7FFF, 1'b1));

    for (int n = 0; n < tbl.size(); n++) begin
      drv(tbl[n].rst, tbl[n].rv, tbl[n].rd, tbl[n].rt, tbl[n].rdy);
      chk($sformatf("tbl%0d.grant", n),     32'(grant),       32'(tbl[n].g));
      chk($sformatf("tbl%0d.out_valid", n), 32'(out_valid),   32'(tbl[n].ov));
      chk($sformatf("tbl%0d.busy", n),      32'(busy),        32'(tbl[n].bz));
      chk($sformatf("tbl%0d.xbar_sel", n),  32'(xbar_sel),    32'(tbl[n].xs));
      chk($sformatf("tbl%0d.err", n),       32'(err_bad_dst), 32'(tbl[n].err));
    end

    // reset clears the sticky error and leaves the idle state
    drv(1'b1, 5'b0, 15'h0, 5'b0, 5'b11111);
    drv(1'b0, 5'b0, 15'h0, 5'b0, 5'b11111);
    chk("rst.err", 32'(err_bad_dst), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.xbar", 32'(xbar_sel), 32'h7FFF);

    // backpressure: 3-flit packet 0 -> 3, out_ready[3] low for 2 cycles
    d3 = pk(3, 0, 0, 0, 0);
    drv(1'b0, 5'b00001, d3, 5'b0, 5'b11111);
    chk("bp.alloc.busy", 32'(busy), 32'h0);
    drv(1'b0, 5'b00001, d3, 5'b0, 5'b11111);
    chk("bp.f1.grant", 32'(grant), 32'h01);
    chk("bp.f1.ov", 32'(out_valid), 32'h08);
    for (int s = 0; s < 2; s++) begin
      drv(1'b0, 5'b00001, d3, 5'b0, 5'b10111);
      chk($sformatf("bp.stall%0d.grant", s), 32'(grant), 32'h0);
      chk($sformatf("bp.stall%0d.ov", s), 32'(out_valid), 32'h0);
      chk($sformatf("bp.stall%0d.busy", s), 32'(busy), 32'h08);
    end
    drv(1'b0, 5'b00001, d3, 5'b0, 5'b11111);
    chk("bp.f2.grant", 32'(grant), 32'h01);
    drv(1'b0, 5'b00001, d3, 5'b00001, 5'b11111);
    chk("bp.f3.grant", 32'(grant), 32'h01);
    chk("bp.f3.busy", 32'(busy), 32'h08);
    drv(1'b0, 5'b0, d3, 5'b0, 5'b11111);
    chk("bp.release.busy", 32'(busy), 32'h0);

    // reset during flit 2 of a 4-flit packet 1 -> 4
    d1 = pk(0, 4, 0, 0, 0);
    drv(1'b0, 5'b00010, d1, 5'b0, 5'b11111);
    drv(1'b0, 5'b00010, d1, 5'b0, 5'b11111);
    chk("rmp.f1.grant", 32'(grant), 32'h02);
    drv(1'b1, 5'b00010, d1, 5'b0, 5'b11111);
    chk("rmp.rst.grant", 32'(grant), 32'h0);
    chk("rmp.rst.ov", 32'(out_valid), 32'h0);
    drv(1'b0, 5'b00010, d1, 5'b0, 5'b11111);
    chk("rmp.after.busy", 32'(busy), 32'h0);
    chk("rmp.after.xbar", 32'(xbar_sel), 32'h7FFF);
    chk("rmp.after.grant", 32'(grant), 32'h0);
    drv(1'b0, 5'b00010, d1, 5'b00010, 5'b11111);
    chk("rmp.realloc.busy", 32'(busy), 32'h10);
    chk("rmp.realloc.xbar", 32'(xbar_sel), 32'(pk(7,7,7,7,1)));
    chk("rmp.realloc.grant", 32'(grant), 32'h02);
    drv(1'b0, 5'b0, d1, 5'b0, 5'b11111);
    chk("rmp.done.busy", 32'(busy), 32'h0);

    // randomized traffic against the reference model
    drv(1'b1, 5'b0, 15'h0, 5'b0, 5'b11111);
    @(posedge clk);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst;
      logic [4:0]  r_rv, r_rt, r_rdy;
      logic [14:0] r_rd;
      r_rst = ($urandom_range(0, 199) == 0);
      r_rv  = 5'($urandom);
      r_rd  = '0;
      r_rt  = '0;
      r_rdy = '0;
      for (int i = 0; i < NP; i++) begin
        r_rd[i*3 +: 3] = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        r_rt[i]  = ($urandom_range(0, 2) == 0);
        r_rdy[i] = ($urandom_range(0, 3) != 0);
      end
      drv(r_rst, r_rv, r_rd, r_rt, r_rdy);
      model_eval(r_rst, r_rv, r_rd, r_rt, r_rdy, e_g, e_ov, e_bz, e_xs, e_err);
      chk($sformatf("rnd%0d.grant", c),     32'(grant),       32'(e_g));
      chk($sformatf("rnd%0d.out_valid", c), 32'(out_valid),   32'(e_ov));
      chk($sformatf("rnd%0d.busy", c),      32'(busy),        32'(e_bz));
      chk($sformatf("rnd%0d.xbar_sel", c),  32'(xbar_sel),    32'(e_xs));
      chk($sformatf("rnd%0d.err", c),       32'(err_bad_dst), 32'(e_err));
      @(posedge clk);
      model_commit();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
